// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack: op encodings and default geometry.
// The control unit imports the same encodings.
package stack_pkg;

  localparam int STACK_WIDTH = 16;
  localparam int STACK_DEPTH = 16;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_PUSH  = 3'b001;
  localparam logic [2:0] OP_POP   = 3'b010;
  localparam logic [2:0] OP_BINOP = 3'b011;
  localparam logic [2:0] OP_UNOP  = 3'b100;
  localparam logic [2:0] OP_DUP   = 3'b101;
  localparam logic [2:0] OP_SWAP  = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

endpackage

// File: rtl/data_stack.sv
// Operand stack feeding the ALU: presents tos/nos from registered state only,
// applies one op per clock, rejects over/underflow and latches a sticky err.
module data_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q;

  logic [CNT_W-1:0] cnt_m1, cnt_m2;
  logic [AW-1:0]    idx_top, idx_nos, idx_new;
  logic             has1, has2, room;
  logic [WIDTH-1:0] tos_raw, nos_raw;

  logic             we_a, we_b, illegal;
  logic [AW-1:0]    idx_a, idx_b;
  logic [WIDTH-1:0] dat_a, dat_b;

  assign cnt_m1  = count_q - CNT_W'(1);
  assign cnt_m2  = count_q - CNT_W'(2);
  assign idx_top = cnt_m1[AW-1:0];
  assign idx_nos = cnt_m2[AW-1:0];
  assign idx_new = count_q[AW-1:0];

  assign has1 = (count_q != '0);
  assign has2 = (count_q >= CNT_W'(2));
  assign room = (count_q < CNT_W'(DEPTH));

  assign tos_raw = mem[idx_top];
  assign nos_raw = mem[idx_nos];

  // Masking keeps uninitialised or popped storage from ever reaching the ALU.
  assign tos   = has1 ? tos_raw : '0;
  assign nos   = has2 ? nos_raw : '0;
  assign count = count_q;
  assign empty = ~has1;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign err   = err_q;

  always_comb begin
    count_d = count_q;
    we_a    = 1'b0;
    idx_a   = idx_new;
    dat_a   = din;
    we_b    = 1'b0;
    idx_b   = idx_nos;
    dat_b   = tos_raw;
    illegal = 1'b0;
    case (op)
      OP_PUSH: begin
        if (room) begin
          we_a    = 1'b1;
          idx_a   = idx_new;
          dat_a   = din;
          count_d = count_q + CNT_W'(1);
        end else begin
          illegal = 1'b1;
        end
      end
      OP_POP: begin
        if (has1) count_d = cnt_m1;
        else      illegal = 1'b1;
      end
      OP_BINOP: begin
        // The result lands where NOS was; the old TOS slot becomes free.
        if (has2) begin
          we_a    = 1'b1;
          idx_a   = idx_nos;
          dat_a   = din;
          count_d = cnt_m1;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_UNOP: begin
        if (has1) begin
          we_a  = 1'b1;
          idx_a = idx_top;
          dat_a = din;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_DUP: begin
        if (has1 && room) begin
          we_a    = 1'b1;
          idx_a   = idx_new;
          dat_a   = tos_raw;
          count_d = count_q + CNT_W'(1);
        end else begin
          illegal = 1'b1;
        end
      end
      OP_SWAP: begin
        if (has2) begin
          we_a  = 1'b1;
          idx_a = idx_top;
          dat_a = nos_raw;
          we_b  = 1'b1;
          idx_b = idx_nos;
          dat_b = tos_raw;
        end else begin
          illegal = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      if (illegal) err_q <= 1'b1;
    end
  end

  // Storage is deliberately not cleared; count masking hides old contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (we_a) mem[idx_a] <= dat_a;
      if (we_b) mem[idx_b] <= dat_b;
    end
  end

endmodule

// File: doc/data_stack.md
Name: data_stack

Overview:
- Operand stack for the 16-bit stack processor. It sits directly upstream of the ALU.
- Holds up to DEPTH words and continuously presents the top two entries as ALU operands: A = nos, B = tos. With this wiring, sub yields NOS−TOS.
- Accepts one stack operation per clock from the control unit. For ALU instructions, the ALU result is written back through din.

Parameters:
- WIDTH, 16, data word width (matches the ALU operand width).
- DEPTH, 16, maximum number of entries; power of two, ≥ 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  3  stack operation for this cycle (encoding below).
- din  in  WIDTH  word to push or write back (immediate, memory data or ALU_Out).
- tos  out  WIDTH  top-of-stack; drives ALU B.
- nos  out  WIDTH  next-on-stack; drives ALU A.
- count  out  CNT_W  current number of entries, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- err  out  1  sticky error flag: an illegal operation was rejected.

Behaviour:
- Op encoding:
  - 000 NOP.
  - 001 PUSH: din becomes the new TOS; count+1.
  - 010 POP: discard TOS; count−1.
  - 011 BINOP: pop two, push din; count−1.
  - 100 UNOP: replace TOS with din; count unchanged.
  - 101 DUP: push copy of TOS; count+1.
  - 110 SWAP: exchange TOS and NOS.
  - 111 reserved: treated as NOP, no error.
- Legality (evaluated on count before the edge):
  - PUSH needs count<DEPTH.
  - DUP needs 1≤count<DEPTH.
  - POP and UNOP need count≥1.
  - BINOP and SWAP need count≥2.
- Illegal op: no change to storage or count. err is set on the next edge and stays set until reset.
- Timing:
  - tos, nos, count, empty and full are combinational functions of registered state only. They never depend on op or din in the same cycle, so there is no combinational loop through the ALU.
  - Every op's effect is visible on the outputs in the cycle after the edge (1-cycle latency).
  - BINOP: the control unit drives din = ALU_Out(nos, tos) in the same cycle. The sampled TOS/NOS are those before the edge.
- Read-back rules:
  - tos = entry[count−1] when count≥1, else 0.
  - nos = entry[count−2] when count≥2, else 0.
  - Outputs never show stale storage contents.
- Storage:
  - DEPTH×WIDTH register array indexed by count-based pointer; no wrap-around.
  - An overflow/underflow attempt is rejected, never wrapped.
  - The array contents are not cleared by reset; only count and err are reset.
- Reset:
  - count=0, err=0, therefore tos=0, nos=0, empty=1, full=0.
  - Reset dominates op in the same cycle.
  - Reset mid-sequence discards all contents.
- Boundaries:
  - PUSH at count=DEPTH−1 gives full=1.
  - POP at count=1 gives empty=1 and tos=0.
  - BINOP at count=2 gives count=1, tos=din, nos=0.
  - SWAP at count=DEPTH is legal.
- No internal reliance on X; all outputs are defined from the first cycle after reset.

Decomposition:
- Package stack_pkg holds:
  - op encodings as localparams: OP_NOP, OP_PUSH, OP_POP, OP_BINOP, OP_UNOP, OP_DUP, OP_SWAP.
  - default WIDTH and DEPTH.
- The control unit and testbench import the same encodings.
- No sub-module is natural: a single module with the register array, count register, legality decode and err flop.

Test Plan:
- Reset, then PUSH 0x0005, PUSH 0x0003 → count=2, tos=0x0003, nos=0x0005, empty=0, err=0.
- From that state, BINOP with din=0x0002 (ALU sub NOS−TOS) → count=1, tos=0x0002, nos=0.
- DUP then SWAP on stack [0x1234]:
  - after DUP: tos=nos=0x1234, count=2.
  - PUSH 0xBEEF, then SWAP: tos=0x1234, nos=0xBEEF.
- Fill to DEPTH with PUSH i → full=1. Then PUSH 0xFFFF → count stays 16, tos unchanged, err=1 and stays 1 through later legal ops.
- Underflow cases, from reset:
  - POP → err=1, count=0.
  - After reset, PUSH 1, then BINOP → rejected, count=1, tos=1, err=1.
  - SWAP with count=1 → likewise rejected.
- Reset while count=7 concurrent with PUSH → next cycle count=0, tos=0, nos=0, empty=1, err=0. The push is ignored.
